axi_slave_arbiter: RTL and testbench

// Schedules one single-ported AXI slave among NUM_MST masters. The slave serves one transaction at a time, so this block serialises all reads and writes.

---
 rtl/axi_slave_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axi_slave_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_arbiter.sv
// Round-robin scheduler that serialises AR and AW requests from several masters
// onto one single-ported AXI slave, with a stall watchdog on the data/response phases.
module axi_slave_arbiter #(
    parameter int NUM_MST = 2,
    parameter int TIMEOUT = 256,
    localparam int NREQ   = 2 * NUM_MST,
    localparam int GW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic               aclk,
    input  logic               areset_n,
    input  logic [NUM_MST-1:0] arvalid_m,
    input  logic [NUM_MST-1:0] awvalid_m,
    input  logic               arvalid_s,
    input  logic               arready_s,
    input  logic               rvalid_s,
    input  logic               rready_s,
    input  logic               rlast_s,
    input  logic               awvalid_s,
    input  logic               awready_s,
    input  logic               wvalid_s,
    input  logic               wready_s,
    input  logic               wlast_s,
    input  logic               bvalid_s,
    input  logic               bready_s,
    output logic [NUM_MST-1:0] ar_gnt,
    output logic [NUM_MST-1:0] aw_gnt,
    output logic [GW-1:0]      gnt_idx,
    output logic               busy,
    output logic               timeout_err
);

    localparam int             WDW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT  = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [GW:0]    NREQ_W    = (GW + 1)'(NREQ);
    localparam logic [GW-1:0]  NUM_MST_W = GW'(NUM_MST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t         state_reg, state_next;
    logic [GW-1:0]  gnt_idx_reg, gnt_idx_next;
    logic [GW-1:0]  last_ptr_reg, last_ptr_next;
    logic [WDW-1:0] wd_cnt_reg, wd_cnt_next;
    logic           timeout_err_reg, timeout_err_next;

    logic [NREQ-1:0] req;
    logic [GW:0]     cand_sum [NREQ];
    logic [GW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;
    logic [GW-1:0]   pick_idx;

    logic is_read;
    logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic beat;
    logic rd_hold, wr_hold;

    assign req = {awvalid_m, arvalid_m};

    // Candidate gi is the requester gi+1 places after the last winner, wrapping at NREQ.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, last_ptr_reg} + (GW + 1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= NREQ_W) ? GW'(cand_sum[gi] - NREQ_W)
                                                           : cand_sum[gi][GW-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    assign is_read = (gnt_idx_reg < NUM_MST_W);
    assign ar_hs   = arvalid_s & arready_s;
    assign aw_hs   = awvalid_s & awready_s;
    assign r_hs    = rvalid_s & rready_s;
    assign w_hs    = wvalid_s & wready_s;
    assign b_hs    = bvalid_s & bready_s;

    // Only beats belonging to the current phase keep the watchdog alive.
    assign beat = ((state_reg == S_DATA) && (is_read ? r_hs : w_hs)) ||
                  ((state_reg == S_RESP) && b_hs);

    always_comb begin
        state_next       = state_reg;
        gnt_idx_next     = gnt_idx_reg;
        last_ptr_next    = last_ptr_reg;
        wd_cnt_next      = wd_cnt_reg;
        timeout_err_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (|req) begin
                    gnt_idx_next = pick_idx;
                    state_next   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (is_read ? ar_hs : aw_hs) begin
                    state_next    = S_DATA;
                    last_ptr_next = gnt_idx_reg;
                    wd_cnt_next   = '0;
                end
            end
            S_DATA, S_RESP: begin
                if (beat) begin
                    wd_cnt_next = '0;
                end else if (wd_cnt_reg != '1) begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end

                if ((TIMEOUT > 0) && !beat && (wd_cnt_reg == WD_LIMIT)) begin
                    state_next       = S_IDLE;
                    timeout_err_next = 1'b1;
                end else if (state_reg == S_DATA) begin
                    if (is_read && r_hs && rlast_s) begin
                        state_next = S_IDLE;
                    end else if (!is_read && w_hs && wlast_s) begin
                        state_next = S_RESP;
                    end
                end else if (b_hs) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_reg       <= S_IDLE;
            gnt_idx_reg     <= '0;
            last_ptr_reg    <= GW'(NREQ - 1);
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            gnt_idx_reg     <= gnt_idx_next;
            last_ptr_reg    <= last_ptr_next;
            wd_cnt_reg      <= wd_cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // Grants decode from registered state, so async reset removes them at once.
    assign rd_hold = is_read && ((state_reg == S_ADDR) || (state_reg == S_DATA));
    assign wr_hold = !is_read && (state_reg != S_IDLE);

    generate
        for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_gnt
            assign ar_gnt[gi] = rd_hold && (gnt_idx_reg == GW'(gi));
            assign aw_gnt[gi] = wr_hold && (gnt_idx_reg == GW'(gi + NUM_MST));
        end
    endgenerate

    assign gnt_idx     = gnt_idx_reg;
    assign busy        = (state_reg != S_IDLE);
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_axi_slave_arbiter.sv
// Directed and randomized bench for axi_slave_arbiter (2 masters, 16-cycle watchdog)
// checked against a round-robin transaction-level reference model.
module tb_axi_slave_arbiter;

    logic       aclk = 1'b0;
    logic       areset_n;
    logic [1:0] arvalid_m, awvalid_m;
    logic       arvalid_s, arready_s, rvalid_s, rready_s, rlast_s;
    logic       awvalid_s, awready_s, wvalid_s, wready_s, wlast_s;
    logic       bvalid_s, bready_s;
    logic [1:0] ar_gnt, aw_gnt;
    logic [1:0] gnt_idx;
    logic       busy, timeout_err;

    int errors = 0;
    int checks = 0;
    int last_w = 3;

    always #5 aclk = ~aclk;

    axi_slave_arbiter #(.NUM_MST(2), .TIMEOUT(16)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .arvalid_m(arvalid_m), .awvalid_m(awvalid_m),
        .arvalid_s(arvalid_s), .arready_s(arready_s),
        .rvalid_s(rvalid_s), .rready_s(rready_s), .rlast_s(rlast_s),
        .awvalid_s(awvalid_s), .awready_s(awready_s),
        .wvalid_s(wvalid_s), .wready_s(wready_s), .wlast_s(wlast_s),
        .bvalid_s(bvalid_s), .bready_s(bready_s),
        .ar_gnt(ar_gnt), .aw_gnt(aw_gnt), .gnt_idx(gnt_idx),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Reference: first requester after the previous winner, cyclically.
    function automatic int model_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [1:0] ar_oh(input int idx);
        return (idx < 2) ? 2'(1 << idx) : 2'b00;
    endfunction

    function automatic logic [1:0] aw_oh(input int idx);
        return (idx >= 2) ? 2'(1 << (idx - 2)) : 2'b00;
    endfunction

    task automatic clear_slave();
        arvalid_s = 0; arready_s = 0; rvalid_s = 0; rready_s = 0; rlast_s = 0;
        awvalid_s = 0; awready_s = 0; wvalid_s = 0; wready_s = 0; wlast_s = 0;
        bvalid_s = 0; bready_s = 0;
    endtask

    task automatic do_reset();
        areset_n  = 1'b0;
        arvalid_m = '0;
        awvalid_m = '0;
        clear_slave();
        step();
        step();
        areset_n = 1'b1;
        last_w   = 3;
    endtask

    task automatic drive_data(input bit rd, input logic v, input logic rdy, input logic lst);
        if (rd) begin
            rvalid_s = v; rready_s = rdy; rlast_s = lst;
        end else begin
            wvalid_s = v; wready_s = rdy; wlast_s = lst;
        end
    endtask

    // One complete transaction with requests r held; returns the observed grant index.
    task automatic run_txn(input logic [3:0] r, input int beats, output int got);
        int  exp;
        bit  rd;
        int  st;
        exp = model_pick(r, last_w);
        rd  = (exp < 2);
        arvalid_m = r[1:0];
        awvalid_m = r[3:2];
        step();
        got = int'(gnt_idx);
        chk("grant_idx", gnt_idx, exp);
        chk("ar_gnt_addr", ar_gnt, ar_oh(exp));
        chk("aw_gnt_addr", aw_gnt, aw_oh(exp));
        chk("busy_addr", busy, 1);
        if ($urandom_range(0, 1) == 1) begin
            if (rd) arvalid_s = 1; else awvalid_s = 1;
            step();
            chk("hold_addr", rd ? ar_gnt : aw_gnt, rd ? ar_oh(exp) : aw_oh(exp));
        end
        if (rd) begin arvalid_s = 1; arready_s = 1; end
        else    begin awvalid_s = 1; awready_s = 1; end
        step();
        clear_slave();
        last_w = exp;
        for (int b = 0; b < beats; b++) begin
            st = $urandom_range(0, 2);
            for (int s = 0; s < st; s++) begin
                drive_data(rd, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
                step();
                chk("hold_data", rd ? ar_gnt : aw_gnt, rd ? ar_oh(exp) : aw_oh(exp));
            end
            drive_data(rd, 1'b1, 1'b1, 1'(b == beats - 1));
            step();
            clear_slave();
            if (b < beats - 1) chk("busy_mid_burst", busy, 1);
        end
        if (!rd) begin
            chk("aw_gnt_resp", aw_gnt, aw_oh(exp));
            chk("busy_resp", busy, 1);
            st = $urandom_range(0, 2);
            for (int s = 0; s < st; s++) begin
                bvalid_s = 1'($urandom_range(0, 1)); bready_s = 0;
                step();
                chk("hold_resp", aw_gnt, aw_oh(exp));
            end
            bvalid_s = 1; bready_s = 1;
            step();
            clear_slave();
        end
        chk("busy_done", busy, 0);
        chk("ar_gnt_done", ar_gnt, 0);
        chk("aw_gnt_done", aw_gnt, 0);
        chk("no_timeout", timeout_err, 0);
        $display("txn req=%b beats=%0d grant=%0d expected=%0d", r, beats, got, exp);
    endtask

    initial begin
        int got;
        logic [3:0] r;

        // Reset state
        areset_n = 1'b0;
        arvalid_m = '0; awvalid_m = '0;
        clear_slave();
        #1;
        chk("rst_ar_gnt", ar_gnt, 0);
        chk("rst_aw_gnt", aw_gnt, 0);
        chk("rst_gnt_idx", gnt_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        step();
        areset_n = 1'b1;
        last_w = 3;

        // Two reads pending: index 0 then index 1
        run_txn(4'b0011, 2, got);
        chk("rd_first", got, 0);
        run_txn(4'b0011, 1, got);
        chk("rd_second", got, 1);

        // Read and write from master 0: read first, then write (idx 2)
        do_reset();
        run_txn(4'b0101, 1, got);
        chk("rw_read_first", got, 0);
        run_txn(4'b0101, 1, got);
        chk("rw_write_next", got, 2);

        // Four-beat write burst
        run_txn(4'b0100, 4, got);

        // All four requesters: strict rotation
        do_reset();
        for (int k = 0; k < 8; k++) begin
            run_txn(4'b1111, int'($urandom_range(1, 3)), got);
            chk("rr_order", got, k % 4);
        end

        // Watchdog abort in read DATA phase
        do_reset();
        arvalid_m = 2'b01;
        step();
        chk("to_rd_grant", ar_gnt, 2'b01);
        arvalid_s = 1; arready_s = 1;
        step();
        clear_slave();
        arvalid_m = 2'b00;
        last_w = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("to_rd_pending", timeout_err, 0);
            chk("to_rd_busy", busy, 1);
        end
        step();
        chk("to_rd_pulse", timeout_err, 1);
        chk("to_rd_idle", busy, 0);
        chk("to_rd_release", ar_gnt, 0);
        step();
        chk("to_rd_pulse_end", timeout_err, 0);
        $display("txn timeout read stall=16 timeout_err seen");

        // Beats clear the watchdog; abort in RESP phase
        awvalid_m = 2'b01;
        step();
        chk("to_wr_idx", gnt_idx, model_pick(4'b0100, last_w));
        chk("to_wr_grant", aw_gnt, 2'b01);
        awvalid_s = 1; awready_s = 1;
        step();
        clear_slave();
        awvalid_m = 2'b00;
        last_w = 2;
        for (int k = 0; k < 12; k++) step();
        wvalid_s = 1; wready_s = 1; wlast_s = 0;
        step();
        clear_slave();
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("to_wr_cleared", timeout_err, 0);
            chk("to_wr_busy", busy, 1);
        end
        wvalid_s = 1; wready_s = 1; wlast_s = 1;
        step();
        clear_slave();
        chk("to_resp_hold", aw_gnt, 2'b01);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("to_resp_pending", timeout_err, 0);
        end
        step();
        chk("to_resp_pulse", timeout_err, 1);
        chk("to_resp_release", aw_gnt, 0);
        chk("to_resp_idle", busy, 0);
        $display("txn timeout resp stall=16 timeout_err seen");

        // Asynchronous reset in the middle of a write burst
        awvalid_m = 2'b10;
        step();
        chk("mid_rst_idx", gnt_idx, model_pick(4'b1000, last_w));
        awvalid_s = 1; awready_s = 1;
        step();
        clear_slave();
        wvalid_s = 1; wready_s = 1; wlast_s = 0;
        step();
        clear_slave();
        chk("mid_rst_before", aw_gnt, 2'b10);
        #3;
        areset_n = 1'b0;
        #1;
        chk("mid_rst_aw_gnt", aw_gnt, 0);
        chk("mid_rst_busy", busy, 0);
        awvalid_m = 2'b00;
        step();
        areset_n = 1'b1;
        last_w = 3;
        run_txn(4'b1111, 2, got);
        chk("post_rst_first", got, 0);

        // Random request patterns
        for (int t = 0; t < 16; t++) begin
            r = 4'($urandom_range(1, 15));
            run_txn(r, int'($urandom_range(1, 4)), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
